irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  GBA interrupt controller. Owns IE (0x200), IF (0x202) and IME (0x208) on the IO bus, beside io_register.
//  Converts video, timer and keypad events into IF bits and drives one registered irq line to the CPU core.
//  Shares the IO bus (addr/data_in/read/write/width) with io_register.
//  The bus mux selects data_out when addr[11:0] is in 0x200..0x20B.
// PARAMETERS
//  VBLANK_LINE  8'd160  vgac_v_addr value at which VBlank starts
//  NUM_TIMERS   4       timer overflow inputs (bits 3..6 of IE/IF)
// PORTS
//  clk_mem      in   1   memory/IO clock; all state in this block is on its rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  addr         in   24  IO bus byte address; only addr[11:0] is decoded
//  data_in      in   32  write data, right-aligned
//  data_out     out  32  read data: selected word >> {addr[1:0],3'b0}
//  read         in   1   read strobe (data_out is combinational; strobe is unused internally)
//  write        in   1   write strobe, one clk_mem cycle per access
//  width        in   2   00 byte, 01 halfword, 1x word
//  vgac_v_addr  in   8   current scanline from the VGA controller
//  vgac_hblank  in   1   high during horizontal blank
//  dispstat     in   16  DISPSTAT from io_register: [5:3] VCnt/HBl/VBl IRQ enable, [15:8] LYC
//  timer_ovf    in   4   1-cycle overflow pulses, already qualified by each timer's IRQ-enable bit
//  key_data     in   10  key state, 0 = pressed
//  keycnt       in   16  KEYCNT: [9:0] select, [14] IRQ enable, [15] 0=OR, 1=AND
//  irq          out  1   registered interrupt request, level
// BEHAVIOUR
//  - Reset: IE=0, IF=0, IME=0, irq=0; all edge-history flops=0, prev_vaddr=VBLANK_LINE.
//  - Register map:
//      word 0x200 = {2'b0,IF[13:0],2'b0,IE[13:0]}
//      word 0x208 = {31'b0,IME}
//      all other words in the window read 0.
//  - Write mask = (width mask) << shift; wdata = (data_in << shift) & mask.
//  - IE: IE <= (IE & ~mask[13:0]) | wdata[13:0]. IME: bit 0 of 0x208 under the same rule.
//  - IF is write-1-to-clear: IF <= IF & ~wdata[29:16]. Only bits written as 1 clear; bits outside the mask never clear.
//  - IF bits: 0 VBlank, 1 HBlank, 2 VCount, 3..6 timer0..3, 12 keypad.
//      bits 7..11 and 13 are hard 0, not writable, and read 0.
//  - Event detection (each a 1-cycle set pulse; evaluated every clk_mem):
//      VBlank  : prev_vaddr != VBLANK_LINE && vgac_v_addr == VBLANK_LINE && dispstat[3]
//      HBlank  : vgac_hblank rising edge && dispstat[4]
//      VCount  : (vgac_v_addr == dispstat[15:8]) rising edge && dispstat[5]
//      Timer n : timer_ovf[n]
//      Keypad  : rising edge of key condition (see CONFIGURATION)
//  - IF next = (IF & ~clear) | set. If a set and a clear hit the same bit in one cycle, the set wins.
//  - irq <= IME & |(IE & IF): one cycle of latency from an IF/IE/IME change.
//  - Deasserting IME drops irq on the next edge; IF is preserved.
//  - A level source held high sets IF only once; it does not re-set after a clear.
//    To re-arm, the source condition must go low and then high again.
//  - Reset mid-frame: edge history is reinitialised; no spurious VBlank fires until the next 159->160 transition.
// CONFIGURATION
//  - Macro: IRQ_KEYPAD_EN.
//  - Defined: the key condition is built from pressed = ~key_data & keycnt[9:0]:
//      keycnt[15]=0 : |pressed
//      keycnt[15]=1 : pressed == keycnt[9:0] (with keycnt[9:0] != 0)
//    The condition is gated by keycnt[14] and drives IF[12] on its rising edge.
//  - Undefined: the keypad logic is removed; IF[12] is constant 0; key_data and keycnt are unused.
// STRUCTURE
//  - Package gba_io_pkg holds:
//      IO address constants (ADDR_IE=12'h200, ADDR_IF=12'h202, ADDR_IME=12'h208)
//      IRQ bit indices (IRQ_VBLANK..IRQ_KEYPAD)
//      IRQ_IMPL_MASK=14'h107F
//      width encoding constants shared with io_register
//  - One sub-module: irq_edge_detect, a 1-bit rising-edge detector with async reset.
//    Instantiated for hblank, vcount-match and keypad.
// TESTING
//  1. Reset, then write word 0x200=32'h0000_0001 and 0x208=1; step vgac_v_addr 159->160 with dispstat[3]=1.
//     -> IF=0x0001; irq=1 one cycle after IF sets.
//  2. With IF=0x0009, write halfword at 0x202 data 0x0008.
//     -> IF=0x0001. A byte write at 0x203 with 0xFF leaves IF unchanged.
//  3. timer_ovf[2] pulses in the same cycle as a W1C write clearing bit 5.
//     -> IF[5]=1 (set wins).
//  4. IE=0x0004, IME=1, dispstat=16'h2A20, vgac_v_addr held at 42 for 100 cycles.
//     -> IF[2] sets once. After it is cleared it does not re-set until the line changes and returns to 42.
//  5. IRQ_KEYPAD_EN set, keycnt=16'hC003, key_data=10'h3FE -> no IF[12]; key_data=10'h3FC -> IF[12]=1.
//     Without the macro, the same stimulus leaves IF[12]=0.
//  6. Assert rst_n low while irq=1 -> irq, IE, IF, IME all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gba_io_pkg.sv
// Shared GBA IO definitions: interrupt register addresses, IRQ bit map and bus width encoding.
package gba_io_pkg;

    localparam logic [11:0] ADDR_IE  = 12'h200;
    localparam logic [11:0] ADDR_IF  = 12'h202;
    localparam logic [11:0] ADDR_IME = 12'h208;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_HBLANK = 1;
    localparam int IRQ_VCOUNT = 2;
    localparam int IRQ_TIMER0 = 3;
    localparam int IRQ_KEYPAD = 12;

    localparam logic [13:0] IRQ_IMPL_MASK = 14'h107F;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Byte-lane mask of an access before it is shifted to its address offset.
    function automatic logic [31:0] width_mask(input logic [1:0] width);
        if (width[1])                return 32'hFFFF_FFFF;
        else if (width == WIDTH_HALF) return 32'h0000_FFFF;
        else                         return 32'h0000_00FF;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// IO bus shared by io_register and irq_controller; the CPU side is the master.
interface irq_controller_if;
    logic [23:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        read;
    logic        write;
    logic [1:0]  width;

    modport master (output addr, data_in, read, write, width, input data_out);
    modport slave  (input addr, data_in, read, write, width, output data_out);
endinterface

// File: rtl/irq_edge_detect.sv
// One-bit rising-edge detector; history flop clears on async reset.
module irq_edge_detect (
    input  logic clk_mem,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= din;
    end

    assign rise = din & ~prev;
endmodule

// File: rtl/irq_controller.sv
// GBA interrupt controller: IE/IF/IME registers and the registered irq line.
// Optional keypad interrupt source is compiled in with IRQ_KEYPAD_EN.
module irq_controller
    import gba_io_pkg::*;
#(
    parameter logic [7:0] VBLANK_LINE = 8'd160,
    parameter int         NUM_TIMERS  = 4
) (
    input  logic                  clk_mem,
    input  logic                  rst_n,
    irq_controller_if.slave       bus,
    input  logic [7:0]            vgac_v_addr,
    input  logic                  vgac_hblank,
    input  logic [15:0]           dispstat,
    input  logic [NUM_TIMERS-1:0] timer_ovf,
    input  logic [9:0]            key_data,
    input  logic [15:0]           keycnt,
    output logic                  irq
);
    logic [13:0] ie_r, if_r, if_set, if_clr;
    logic        ime_r;
    logic [7:0]  prev_vaddr;
    logic [4:0]  shift;
    logic [31:0] wmask, wdata, rd_word;
    logic        sel_ctl, sel_ime;
    logic        hblank_rise, vcount_rise, key_rise;

    assign shift   = {bus.addr[1:0], 3'b000};
    assign sel_ctl = (bus.addr[11:2] == ADDR_IE[11:2]);
    assign sel_ime = (bus.addr[11:2] == ADDR_IME[11:2]);
    assign wmask   = width_mask(bus.width) << shift;
    assign wdata   = (bus.data_in << shift) & wmask;

    always_comb begin
        rd_word = '0;
        if (sel_ctl)      rd_word = {2'b00, if_r, 2'b00, ie_r};
        else if (sel_ime) rd_word = {31'b0, ime_r};
    end
    assign bus.data_out = rd_word >> shift;

    irq_edge_detect u_hblank (.clk_mem(clk_mem), .rst_n(rst_n), .din(vgac_hblank), .rise(hblank_rise));
    irq_edge_detect u_vcount (.clk_mem(clk_mem), .rst_n(rst_n),
                              .din(vgac_v_addr == dispstat[15:8]), .rise(vcount_rise));

`ifdef IRQ_KEYPAD_EN
    logic [9:0] pressed;
    logic       key_cond;
    logic       unused_key;

    assign pressed  = ~key_data & keycnt[9:0];
    // AND mode needs a non-empty select, otherwise an idle pad would match.
    assign key_cond = keycnt[14] & (keycnt[15] ? ((pressed == keycnt[9:0]) && |keycnt[9:0])
                                               : |pressed);
    assign unused_key = ^keycnt[13:10];

    irq_edge_detect u_keypad (.clk_mem(clk_mem), .rst_n(rst_n), .din(key_cond), .rise(key_rise));
`else
    logic unused_key;
    assign key_rise   = 1'b0;
    assign unused_key = ^{key_data, keycnt};
`endif

    always_comb begin
        if_set = '0;
        if_set[IRQ_VBLANK] = (prev_vaddr != VBLANK_LINE) && (vgac_v_addr == VBLANK_LINE) && dispstat[3];
        if_set[IRQ_HBLANK] = hblank_rise & dispstat[4];
        if_set[IRQ_VCOUNT] = vcount_rise & dispstat[5];
        if_set[IRQ_TIMER0 +: NUM_TIMERS] = timer_ovf;
        if_set[IRQ_KEYPAD] = key_rise;
    end

    assign if_clr = (bus.write && sel_ctl) ? wdata[29:16] : '0;

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            ie_r       <= '0;
            if_r       <= '0;
            ime_r      <= 1'b0;
            irq        <= 1'b0;
            prev_vaddr <= VBLANK_LINE;
        end else begin
            if (bus.write && sel_ctl) ie_r  <= (ie_r & ~wmask[13:0]) | wdata[13:0];
            if (bus.write && sel_ime) ime_r <= (ime_r & ~wmask[0]) | wdata[0];
            // Set after clear so a same-cycle event survives a W1C write.
            if_r       <= ((if_r & ~if_clr) | if_set) & IRQ_IMPL_MASK;
            irq        <= ime_r & |(ie_r & if_r);
            prev_vaddr <= vgac_v_addr;
        end
    end

    logic unused_bus;
    assign unused_bus = ^{bus.read, bus.addr[23:12], wdata[31:30], wdata[15:14],
                          wmask[31:14], dispstat[7:6], dispstat[2:0], unused_key};
endmodule
